hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3, meaning in-flight stages tracked after decode (EX, MEM, WB); legal range 2..6.
REQ-002 The block SHALL have parameter FWD_EN, default 1, meaning forwarding paths exist (1) or do not exist (0).
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning the width of the stall performance counter.
REQ-004 The block SHALL run on one clock and an asynchronous active-low reset, ports as follows:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode holds a real instruction.
- dec_rs, dec_rt  in  5 each  decode source registers.
- dec_uses_rs, dec_uses_rt  in  1 each  source actually read.
- dec_is_branch  in  1  BEQ/BNE in decode (resolved in decode).
- dec_wen, dec_dest, dec_is_load  in  1/5/1  decode write-enable, destination, load flag.
- ex_branch_taken  in  1  jump/branch redirect from EX.
- dmem_req  in  1  MEM stage has LW/SW outstanding.
- dmem_ready  in  1  data memory done this cycle.
- pc_en, fd_en  out  1 each  fetch and decode register enables.
- fd_flush, dx_flush  out  1 each  bubble insertion.
- xm_en, mw_en  out  1 each  back-end latch enables.
- stall_cnt  out  CNT_W  cycles with decode stalled.

Function
REQ-005 Scoreboard: DEPTH entries {valid, dest, is_load}, entry 0 = EX; entries SHALL advance one position per cycle when not frozen.
REQ-006 Entry 0 SHALL load {dec_valid & dec_wen & ~stall & ~dx_flush, dec_dest, dec_is_load}; otherwise a bubble (valid=0).
REQ-007 Matches SHALL compare only used sources; register 0 SHALL never match.
REQ-008 With FWD_EN=1, raw_stall SHALL be asserted on a load match in entry 0, or on a dec_is_branch match with any valid entry 0, or a load in entry 1.
REQ-009 With FWD_EN=0, raw_stall SHALL be asserted on a match with any valid entry 0..DEPTH-2; entry DEPTH-1 (WB) writes first-half.
REQ-010 The FSM SHALL have states RUN, MEMWAIT, REDIRECT.
REQ-011 RUN -> MEMWAIT when dmem_req & ~dmem_ready; MEMWAIT -> RUN when dmem_ready.
REQ-012 RUN -> REDIRECT when ex_branch_taken and no memory wait; REDIRECT -> RUN after one cycle.
REQ-013 MEMWAIT SHALL override everything: all enables low, no flushes, scoreboard frozen, ex_branch_taken held by the pipeline.
REQ-014 raw_stall in RUN SHALL produce pc_en=0, fd_en=0, dx_flush=1, xm_en=1, mw_en=1.
REQ-015 Redirect (taken in RUN) SHALL produce fd_flush=1, dx_flush=1, pc_en=1 combinationally in the same cycle, and shall win over raw_stall.
REQ-016 In REDIRECT, all entries SHALL be invalidated once, then normal operation resumes.
REQ-017 Otherwise all enables SHALL be 1 and all flushes 0.
REQ-018 stall_cnt SHALL increment every cycle fd_en=0 and saturate at all-ones.
REQ-019 A memory-wait entry in the same cycle as raw_stall SHALL take MEMWAIT; raw_stall SHALL be re-evaluated on exit.

Reset
REQ-020 On nRST low: FSM=RUN, all scoreboard valid=0, stall_cnt=0, effective immediately (asynchronous).
REQ-021 Outputs after reset SHALL be pc_en=fd_en=xm_en=mw_en=1, flushes 0, until inputs demand otherwise.
REQ-022 Reset asserted during MEMWAIT SHALL abort the wait with no residual freeze.

Structure
REQ-023 The FSM enum hazard_state_t and scoreboard entry struct sb_entry_t SHALL live in cpu_types_pkg; regbits_t is reused.
REQ-024 The shift register SHALL be sub-module hazard_sb_pipe (parameter DEPTH, ports CLK, nRST, shift, clear, in_entry, entries).
REQ-025 The implementation SHALL stay within 120-400 RTL lines with no latches.

Verification
REQ-026 Load-use: LW $2 then ADD $3,$2,$4 (FWD_EN=1) -> exactly one cycle pc_en=0, dx_flush=1, stall_cnt=1.
REQ-027 Branch dependency: ADD $5 then BEQ $5,$0 -> one stall; LW $5 then BEQ $5 -> two stalls.
REQ-028 No forwarding (FWD_EN=0, DEPTH=3): ADD $7 then SUB $8,$7 -> two stall cycles; reads of $0 -> zero stalls.
REQ-029 Memory wait: dmem_req with ready 4 cycles later -> 4 cycles all enables 0, scoreboard unchanged, stall_cnt+=4.
REQ-030 Redirect with concurrent load-use -> fd_flush=1, dx_flush=1, pc_en=1; next cycle all entries invalid.
REQ-031 Reset in MEMWAIT, and stall_cnt saturation with CNT_W=4 -> stays at 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types for hazard detection and the scoreboard.
package cpu_types_pkg;
  typedef logic [4:0] regbits_t;
  typedef enum logic [1:0] {RUN, MEMWAIT, REDIRECT} hazard_state_t;
  typedef struct packed {
    logic     valid;
    regbits_t dest;
    logic     is_load;
  } sb_entry_t;
  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic sb_hit(input regbits_t src, input logic used, input sb_entry_t e);
    return used && src != '0 && e.valid && e.dest == src;
  endfunction
endpackage

// File: rtl/hazard_sb_pipe.sv
// hazard_sb_pipe: in-flight destination shift register, entry 0 = EX.
module hazard_sb_pipe
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      shift,
  input  logic      clear,
  input  sb_entry_t in_entry,
  output sb_entry_t entries [DEPTH]
);
  sb_entry_t entries_q [DEPTH];
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (shift) begin
      entries_q[0] <= in_entry;
      for (int i = 1; i < DEPTH; i++) entries_q[i] <= entries_q[i-1];
    end
  end
  assign entries = entries_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW/branch hazard detection, memory-wait freeze and redirect flush control.
module hazard_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dec_valid,
  input  regbits_t         dec_rs,
  input  regbits_t         dec_rt,
  input  logic             dec_uses_rs,
  input  logic             dec_uses_rt,
  input  logic             dec_is_branch,
  input  logic             dec_wen,
  input  regbits_t         dec_dest,
  input  logic             dec_is_load,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_en,
  output logic             mw_en,
  output logic [CNT_W-1:0] stall_cnt
);
  // WB writes in the first half of the cycle, so only stages before it matter without forwarding.
  localparam logic [DEPTH-1:0] PRE_WB = {1'b0, {(DEPTH-1){1'b1}}};
  hazard_state_t    state_q;
  sb_entry_t        ent [DEPTH];
  sb_entry_t        in_e;
  logic [DEPTH-1:0] m;
  logic             fwd_raw, raw_stall, freeze, redirect, stall;
  logic [CNT_W-1:0] stall_cnt_q;
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      m[i] = sb_hit(dec_rs, dec_uses_rs, ent[i]) | sb_hit(dec_rt, dec_uses_rt, ent[i]);
  end
  // Branches resolve in decode, so they need results one stage earlier than ALU ops.
  assign fwd_raw   = (m[0] & ent[0].is_load) | (dec_is_branch & (m[0] | (m[1] & ent[1].is_load)));
  assign raw_stall = dec_valid & (FWD_EN ? fwd_raw : |(m & PRE_WB));
  assign freeze    = (state_q == MEMWAIT) ? ~dmem_ready : (state_q == RUN) & dmem_req & ~dmem_ready;
  assign redirect  = ~freeze & (state_q != REDIRECT) & ex_branch_taken;
  assign stall     = ~freeze & ~redirect & raw_stall;
  assign pc_en     = ~freeze & ~stall;
  assign fd_en     = ~freeze & ~stall;
  assign fd_flush  = redirect;
  assign dx_flush  = redirect | stall;
  assign xm_en     = ~freeze;
  assign mw_en     = ~freeze;
  assign stall_cnt = stall_cnt_q;
  assign in_e      = '{valid: dec_valid & dec_wen & ~dx_flush, dest: dec_dest, is_load: dec_is_load};
  hazard_sb_pipe #(.DEPTH(DEPTH)) u_pipe (
    .CLK      (CLK),
    .nRST     (nRST),
    .shift    (~freeze),
    .clear    (state_q == REDIRECT),
    .in_entry (in_e),
    .entries  (ent)
  );
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q <= freeze ? MEMWAIT : redirect ? REDIRECT : RUN;
      if (!fd_en && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios on forwarding, no-forwarding and narrow-counter instances.
module tb_hazard_scoreboard;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic dec_valid, dec_uses_rs, dec_uses_rt, dec_is_branch, dec_wen, dec_is_load;
  logic ex_branch_taken, dmem_req, dmem_ready;
  logic [4:0] dec_rs, dec_rt, dec_dest;
  logic [2:0] pc_en, fd_en, fd_flush, dx_flush, xm_en, mw_en;
  logic [31:0] cnt_f, cnt_n;
  logic [3:0] cnt_s;
  logic [5:0] o_f, o_n;
  int errors = 0;
  int checks = 0;
  localparam logic [5:0] NORM = 6'b110011, STL = 6'b000111, RED = 6'b111111, FRZ = 6'b000000;
  always #5 CLK = ~CLK;
  assign o_f = {pc_en[0], fd_en[0], fd_flush[0], dx_flush[0], xm_en[0], mw_en[0]};
  assign o_n = {pc_en[1], fd_en[1], fd_flush[1], dx_flush[1], xm_en[1], mw_en[1]};
  hazard_scoreboard u_fwd (
    .CLK(CLK), .nRST(nRST), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_is_branch(dec_is_branch),
    .dec_wen(dec_wen), .dec_dest(dec_dest), .dec_is_load(dec_is_load),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en[0]), .fd_en(fd_en[0]), .fd_flush(fd_flush[0]), .dx_flush(dx_flush[0]),
    .xm_en(xm_en[0]), .mw_en(mw_en[0]), .stall_cnt(cnt_f)
  );
  hazard_scoreboard #(.DEPTH(3), .FWD_EN(1'b0)) u_nofwd (
    .CLK(CLK), .nRST(nRST), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_is_branch(dec_is_branch),
    .dec_wen(dec_wen), .dec_dest(dec_dest), .dec_is_load(dec_is_load),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en[1]), .fd_en(fd_en[1]), .fd_flush(fd_flush[1]), .dx_flush(dx_flush[1]),
    .xm_en(xm_en[1]), .mw_en(mw_en[1]), .stall_cnt(cnt_n)
  );
  hazard_scoreboard #(.CNT_W(4)) u_sat (
    .CLK(CLK), .nRST(nRST), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt), .dec_is_branch(dec_is_branch),
    .dec_wen(dec_wen), .dec_dest(dec_dest), .dec_is_load(dec_is_load),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en[2]), .fd_en(fd_en[2]), .fd_flush(fd_flush[2]), .dx_flush(dx_flush[2]),
    .xm_en(xm_en[2]), .mw_en(mw_en[2]), .stall_cnt(cnt_s)
  );
  task automatic idle();
    dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_uses_rs = 0; dec_uses_rt = 0;
    dec_is_branch = 0; dec_wen = 0; dec_dest = 0; dec_is_load = 0;
    ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask
  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic br, input logic wen, input logic [4:0] dest, input logic ld);
    dec_valid = 1; dec_rs = rs; dec_rt = rt; dec_uses_rs = urs; dec_uses_rt = urt;
    dec_is_branch = br; dec_wen = wen; dec_dest = dest; dec_is_load = ld;
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    idle();
    nRST = 0;
    tick();
    nRST = 1;
  endtask
  task automatic test_reset();
    idle();
    nRST = 0;
    tick();
    #2;
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL rst_outputs: got %b want %b", o_f, NORM); end
    checks++; if (cnt_f !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", cnt_f); end
    tick();
    nRST = 1;
    #2;
    checks++; if (o_n !== NORM) begin errors++; $display("FAIL rst_release: got %b want %b", o_n, NORM); end
    tick();
  endtask
  task automatic test_load_use();
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 2, 1);
    #2;
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL lu_load: got %b want %b", o_f, NORM); end
    tick();
    instr(2, 4, 1, 1, 0, 1, 3, 0);
    #2;
    checks++; if (o_f !== STL) begin errors++; $display("FAIL lu_stall: got %b want %b", o_f, STL); end
    tick();
    #2;
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL lu_release: got %b want %b", o_f, NORM); end
    checks++; if (cnt_f !== 32'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", cnt_f); end
    tick();
    idle();
    #2;
    checks++; if (cnt_f !== 32'd1) begin errors++; $display("FAIL lu_cnt_hold: got %0d want 1", cnt_f); end
    tick();
  endtask
  task automatic test_branch();
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 5, 0);
    tick();
    instr(5, 0, 1, 1, 1, 0, 0, 0);
    #2;
    checks++; if (o_f !== STL) begin errors++; $display("FAIL br_alu_stall: got %b want %b", o_f, STL); end
    tick();
    #2;
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL br_alu_go: got %b want %b", o_f, NORM); end
    checks++; if (cnt_f !== 32'd1) begin errors++; $display("FAIL br_alu_cnt: got %0d want 1", cnt_f); end
    tick();
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 5, 1);
    tick();
    instr(5, 0, 1, 1, 1, 0, 0, 0);
    #2;
    checks++; if (o_f !== STL) begin errors++; $display("FAIL br_lw_s1: got %b want %b", o_f, STL); end
    tick();
    #2;
    checks++; if (o_f !== STL) begin errors++; $display("FAIL br_lw_s2: got %b want %b", o_f, STL); end
    tick();
    #2;
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL br_lw_go: got %b want %b", o_f, NORM); end
    checks++; if (cnt_f !== 32'd2) begin errors++; $display("FAIL br_lw_cnt: got %0d want 2", cnt_f); end
    tick();
  endtask
  task automatic test_no_fwd();
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 7, 0);
    tick();
    instr(7, 0, 1, 1, 0, 1, 8, 0);
    #2;
    checks++; if (o_n !== STL) begin errors++; $display("FAIL nf_s1: got %b want %b", o_n, STL); end
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL nf_fwd_free: got %b want %b", o_f, NORM); end
    tick();
    #2;
    checks++; if (o_n !== STL) begin errors++; $display("FAIL nf_s2: got %b want %b", o_n, STL); end
    tick();
    #2;
    checks++; if (o_n !== NORM) begin errors++; $display("FAIL nf_wb: got %b want %b", o_n, NORM); end
    checks++; if (cnt_n !== 32'd2) begin errors++; $display("FAIL nf_cnt: got %0d want 2", cnt_n); end
    tick();
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    instr(0, 0, 1, 1, 0, 1, 1, 0);
    #2;
    checks++; if (o_n !== NORM) begin errors++; $display("FAIL r0_nofwd: got %b want %b", o_n, NORM); end
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL r0_fwd: got %b want %b", o_f, NORM); end
    tick();
    #2;
    checks++; if (cnt_n !== 32'd0) begin errors++; $display("FAIL r0_cnt: got %0d want 0", cnt_n); end
    tick();
  endtask
  task automatic test_memwait();
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 2, 1);
    tick();
    instr(2, 4, 1, 1, 0, 1, 3, 0);
    dmem_req = 1;
    dmem_ready = 0;
    #2;
    checks++; if (o_f !== FRZ) begin errors++; $display("FAIL mw_enter: got %b want %b", o_f, FRZ); end
    tick();
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (o_f !== FRZ) begin errors++; $display("FAIL mw_hold%0d: got %b want %b", i, o_f, FRZ); end
      tick();
    end
    dmem_ready = 1;
    #2;
    checks++; if (cnt_f !== 32'd4) begin errors++; $display("FAIL mw_cnt: got %0d want 4", cnt_f); end
    checks++; if (o_f !== STL) begin errors++; $display("FAIL mw_exit_raw: got %b want %b", o_f, STL); end
    tick();
    dmem_req = 0;
    dmem_ready = 0;
    #2;
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL mw_resume: got %b want %b", o_f, NORM); end
    checks++; if (cnt_f !== 32'd5) begin errors++; $display("FAIL mw_cnt_end: got %0d want 5", cnt_f); end
    tick();
  endtask
  task automatic test_redirect();
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 2, 1);
    tick();
    instr(2, 4, 1, 1, 0, 1, 3, 0);
    ex_branch_taken = 1;
    #2;
    checks++; if (o_f !== RED) begin errors++; $display("FAIL rd_fwd: got %b want %b", o_f, RED); end
    checks++; if (o_n !== RED) begin errors++; $display("FAIL rd_nofwd: got %b want %b", o_n, RED); end
    tick();
    ex_branch_taken = 0;
    instr(0, 0, 0, 0, 0, 1, 9, 1);
    #2;
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL rd_state: got %b want %b", o_f, NORM); end
    tick();
    instr(9, 0, 1, 0, 0, 1, 10, 0);
    #2;
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL rd_cleared: got %b want %b", o_f, NORM); end
    checks++; if (o_n !== NORM) begin errors++; $display("FAIL rd_cleared_nf: got %b want %b", o_n, NORM); end
    checks++; if (cnt_f !== 32'd0) begin errors++; $display("FAIL rd_cnt: got %0d want 0", cnt_f); end
    tick();
  endtask
  task automatic test_reset_memwait();
    do_reset();
    dmem_req = 1;
    dmem_ready = 0;
    tick();
    #2;
    checks++; if (o_f !== FRZ) begin errors++; $display("FAIL rm_wait: got %b want %b", o_f, FRZ); end
    #1;
    nRST = 0;
    dmem_req = 0;
    #1;
    checks++; if (cnt_f !== 32'd0) begin errors++; $display("FAIL rm_async_cnt: got %0d want 0", cnt_f); end
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL rm_async_out: got %b want %b", o_f, NORM); end
    tick();
    nRST = 1;
    #2;
    checks++; if (o_f !== NORM) begin errors++; $display("FAIL rm_after: got %b want %b", o_f, NORM); end
    tick();
  endtask
  task automatic test_saturation();
    do_reset();
    dmem_req = 1;
    dmem_ready = 0;
    repeat (15) tick();
    #2;
    checks++; if (cnt_s !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d want 15", cnt_s); end
    repeat (5) tick();
    #2;
    checks++; if (cnt_s !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", cnt_s); end
    checks++; if (cnt_f !== 32'd20) begin errors++; $display("FAIL sat_wide: got %0d want 20", cnt_f); end
    do_reset();
  endtask
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_no_fwd();
    test_memwait();
    test_redirect();
    test_reset_memwait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
